ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have parameter FULL_ALU, default 1; 1 = RV32I ALU set incl. XOR/SLT/SLTU/SRA, 0 = ADD/SUB/AND/OR/SLL/SRL only.
REQ-002 SHALL have parameter FULL_BR, default 1; 1 = all six branches, 0 = BEQ/BNE only.
REQ-003 SHALL use one clock, clk; reset rst_n is asynchronous and active-low.
REQ-004 Ports, in order:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- instr_d  in  32  decode-stage instruction
- valid_d  in  1  instr_d is live
- flush_e  in  1  load bubble into E
- zero_e, lt_e, ltu_e  in  1 each  E-stage ALU flags
- imm_src_d  out  3  I=000 S=001 B=010 U=011 J=100
- illegal_d  out  1  unsupported encoding
- reg_write_e/m/w  out  1  per-stage register write
- result_src_e/m/w  out  2  ALU=00 MEM=01 PC+4=10
- mem_write_e/m  out  1  store
- alu_ctrl_e  out  4  ALU op
- alu_src_a_e  out  2  rs1=00 PC=01 zero=10
- alu_src_b_e  out  1  reg=0 imm=1
- jump_e, jalr_e, branch_e  out  1  control-flow class
- pc_src_e  out  1  redirect fetch
- valid_e/m/w, illegal_w  out  1  stage valid, illegal retired

Function
REQ-005 SHALL decode instr_d combinationally into imm_src_d, illegal_d and a D-stage control bundle.
REQ-006 alu_ctrl SHALL be: ADD 0000, SUB 0001, AND 0010, OR 0011, SLL 0100, SRL 0101, XOR 0110, SLT 0111, SLTU 1000, SRA 1001.
REQ-007 R-type SHALL select op from {funct7,funct3}; OP-IMM SHALL use funct3 only, except shifts, which also check funct7 (0000000 or 0100000 for SRAI).
REQ-008 LW: MEM result, imm I, src_b imm, ADD.
REQ-009 SW: mem_write, imm S, ADD, no reg write.
REQ-010 LUI: src_a zero, imm U, ADD.
REQ-011 AUIPC: src_a PC, imm U, ADD, ALU result.
REQ-012 JAL: imm J, jump, PC+4 result.
REQ-013 JALR: imm I, jump, jalr, src_a rs1, src_b imm, ADD, PC+4 result.
REQ-014 Branch: imm B, branch, SUB; funct3 latched to E as br_type.
REQ-015 Unsupported opcode, funct, or op disabled by FULL_ALU/FULL_BR SHALL raise illegal_d and zero every write/jump/branch control in the bundle.
REQ-016 reg_write SHALL be forced 0 when rd (instr_d[11:7]) == 0.
REQ-017 On each clk edge: D→E, E→M, M→W; one-cycle latency per stage.
REQ-018 valid_d=0 or flush_e=1 SHALL load an all-zero bubble into E; flush_e wins over valid_d.
REQ-019 M and W SHALL advance normally during flush_e.
REQ-020 pc_src_e = valid_e & (jump_e | (branch_e & taken)); taken: BEQ zero, BNE !zero, BLT lt, BGE !lt, BLTU ltu, BGEU !ltu.
REQ-021 illegal SHALL pipeline with valid through E and M to illegal_w; a flush drops it.

Reset
REQ-022 rst_n low SHALL asynchronously clear every E/M/W register, giving all registered outputs and pc_src_e value 0.
REQ-023 Release SHALL be synchronised externally; the first edge after release captures instr_d normally.

Structure
REQ-024 Encodings (imm_src, result_src, alu_src_a, alu_ctrl, opcodes) SHALL live in package ctrl_pkg.
REQ-025 Decode logic SHALL be sub-module ctrl_decode (combinational); ctrl_pipe holds the stage registers and branch resolution.

Verification
REQ-026 0x00208033 (add x0,x1,x2), valid_d=1 → after 1 edge reg_write_e=0, alu_ctrl_e=0000, valid_e=1.
REQ-027 0x4020D1B3 (sra x3,x1,x2): FULL_ALU=1 → alu_ctrl_e=1001, reg_write_e=1; FULL_ALU=0 → illegal_d=1, illegal_w=1 three edges later, reg_write_w=0.
REQ-028 0x00208463 (beq) with zero_e=1 → pc_src_e=1; zero_e=0 → 0; 0x0020C463 (blt), lt_e=1 → pc_src_e=1.
REQ-029 0x0000A183 (lw x3,0(x1)), flush_e=1 same cycle → valid_e=0, reg_write_e=0; next cycle valid lw → result_src_m=01 two edges later.
REQ-030 Issue JAL 0x008000EF, drop rst_n mid-pipe → all outputs 0 immediately, no clk edge needed.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings and control-bundle types for the ctrl_pipe decode/pipeline slice.
// Every field value that crosses a module boundary is defined here.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] SRCA_RS1  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic [3:0] alu_ctrl;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic       jump;
    logic       jalr;
    logic       branch;
    logic [2:0] br_type;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
  } mem_stage_t;

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       reg_write;
    logic [1:0] result_src;
  } wb_stage_t;

  // Branch condition from funct3 and the E-stage ALU flags.
  function automatic logic br_taken(input logic [2:0] br_type, input logic zero,
                                    input logic lt, input logic ltu);
    logic taken;
    case (br_type)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I subset decoder producing the immediate selector and D-stage control bundle.
// Illegal encodings yield an all-zero bundle with only the illegal flag set.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int FULL_ALU = 1,
  parameter int FULL_BR  = 1
) (
  input  logic [31:0] instr,
  output logic [2:0]  imm_src,
  output ctrl_t       ctrl
);

  localparam logic FULL_ALU_B = (FULL_ALU != 0);
  localparam logic FULL_BR_B  = (FULL_BR != 0);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       legal;
  logic       unused_reg_fields;

  assign opcode            = instr[6:0];
  assign rd                = instr[11:7];
  assign funct3            = instr[14:12];
  assign funct7            = instr[31:25];
  assign unused_reg_fields = ^instr[24:15];

  always_comb begin
    ctrl    = '0;
    imm_src = IMM_I;
    legal   = 1'b1;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: ctrl.alu_ctrl = ALU_ADD;
          10'b0100000_000: ctrl.alu_ctrl = ALU_SUB;
          10'b0000000_111: ctrl.alu_ctrl = ALU_AND;
          10'b0000000_110: ctrl.alu_ctrl = ALU_OR;
          10'b0000000_001: ctrl.alu_ctrl = ALU_SLL;
          10'b0000000_101: ctrl.alu_ctrl = ALU_SRL;
          10'b0000000_100: begin ctrl.alu_ctrl = ALU_XOR;  legal = FULL_ALU_B; end
          10'b0000000_010: begin ctrl.alu_ctrl = ALU_SLT;  legal = FULL_ALU_B; end
          10'b0000000_011: begin ctrl.alu_ctrl = ALU_SLTU; legal = FULL_ALU_B; end
          10'b0100000_101: begin ctrl.alu_ctrl = ALU_SRA;  legal = FULL_ALU_B; end
          default:         legal = 1'b0;
        endcase
      end
      OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        case (funct3)
          3'b000: ctrl.alu_ctrl = ALU_ADD;
          3'b111: ctrl.alu_ctrl = ALU_AND;
          3'b110: ctrl.alu_ctrl = ALU_OR;
          3'b100: begin ctrl.alu_ctrl = ALU_XOR;  legal = FULL_ALU_B; end
          3'b010: begin ctrl.alu_ctrl = ALU_SLT;  legal = FULL_ALU_B; end
          3'b011: begin ctrl.alu_ctrl = ALU_SLTU; legal = FULL_ALU_B; end
          3'b001: begin ctrl.alu_ctrl = ALU_SLL;  legal = (funct7 == 7'b0000000); end
          3'b101: begin
            // Shift-immediates reuse funct7 to pick logical vs arithmetic.
            if (funct7 == 7'b0000000) begin
              ctrl.alu_ctrl = ALU_SRL;
            end else if (funct7 == 7'b0100000) begin
              ctrl.alu_ctrl = ALU_SRA;
              legal         = FULL_ALU_B;
            end else begin
              legal = 1'b0;
            end
          end
          default: legal = 1'b0;
        endcase
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.alu_src_b  = 1'b1;
        legal           = (funct3 == 3'b010);
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        imm_src        = IMM_S;
        legal          = (funct3 == 3'b010);
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_a = SRCA_ZERO;
        ctrl.alu_src_b = 1'b1;
        imm_src        = IMM_U;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = 1'b1;
        imm_src        = IMM_U;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = 1'b1;
        ctrl.jump       = 1'b1;
        imm_src         = IMM_J;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.alu_src_b  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.jalr       = 1'b1;
        legal           = (funct3 == 3'b000);
      end
      OP_BRANCH: begin
        ctrl.branch   = 1'b1;
        ctrl.alu_ctrl = ALU_SUB;
        ctrl.br_type  = funct3;
        imm_src       = IMM_B;
        case (funct3)
          3'b000, 3'b001:                 legal = 1'b1;
          3'b100, 3'b101, 3'b110, 3'b111: legal = FULL_BR_B;
          default:                        legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
      imm_src      = IMM_I;
    end else begin
      ctrl.reg_write = ctrl.reg_write & (rd != 5'd0);
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// D->E->M->W control pipeline around ctrl_decode, with E-stage branch resolution.
// Flush or an invalid D slot loads an all-zero bubble into E; M and W keep advancing.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int FULL_ALU = 1,
  parameter int FULL_BR  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  input  logic        flush_e,
  input  logic        zero_e,
  input  logic        lt_e,
  input  logic        ltu_e,
  output logic [2:0]  imm_src_d,
  output logic        illegal_d,
  output logic        reg_write_e,
  output logic        reg_write_m,
  output logic        reg_write_w,
  output logic [1:0]  result_src_e,
  output logic [1:0]  result_src_m,
  output logic [1:0]  result_src_w,
  output logic        mem_write_e,
  output logic        mem_write_m,
  output logic [3:0]  alu_ctrl_e,
  output logic [1:0]  alu_src_a_e,
  output logic        alu_src_b_e,
  output logic        jump_e,
  output logic        jalr_e,
  output logic        branch_e,
  output logic        pc_src_e,
  output logic        valid_e,
  output logic        valid_m,
  output logic        valid_w,
  output logic        illegal_w
);

  ctrl_t      ctrl_dec;
  ctrl_t      e_d, e_q;
  logic       valid_e_d, valid_e_q;
  mem_stage_t m_d, m_q;
  wb_stage_t  w_d, w_q;

  ctrl_decode #(
    .FULL_ALU(FULL_ALU),
    .FULL_BR (FULL_BR)
  ) u_decode (
    .instr  (instr_d),
    .imm_src(imm_src_d),
    .ctrl   (ctrl_dec)
  );

  assign illegal_d = ctrl_dec.illegal;

  always_comb begin
    if (flush_e || !valid_d) begin
      e_d       = '0;
      valid_e_d = 1'b0;
    end else begin
      e_d       = ctrl_dec;
      valid_e_d = 1'b1;
    end
    m_d.valid      = valid_e_q;
    m_d.illegal    = e_q.illegal;
    m_d.reg_write  = e_q.reg_write;
    m_d.result_src = e_q.result_src;
    m_d.mem_write  = e_q.mem_write;
    w_d.valid      = m_q.valid;
    w_d.illegal    = m_q.illegal;
    w_d.reg_write  = m_q.reg_write;
    w_d.result_src = m_q.result_src;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q       <= '0;
      valid_e_q <= 1'b0;
      m_q       <= '0;
      w_q       <= '0;
    end else begin
      e_q       <= e_d;
      valid_e_q <= valid_e_d;
      m_q       <= m_d;
      w_q       <= w_d;
    end
  end

  assign reg_write_e  = e_q.reg_write;
  assign result_src_e = e_q.result_src;
  assign mem_write_e  = e_q.mem_write;
  assign alu_ctrl_e   = e_q.alu_ctrl;
  assign alu_src_a_e  = e_q.alu_src_a;
  assign alu_src_b_e  = e_q.alu_src_b;
  assign jump_e       = e_q.jump;
  assign jalr_e       = e_q.jalr;
  assign branch_e     = e_q.branch;
  assign valid_e      = valid_e_q;
  assign pc_src_e     = valid_e_q &
                        (e_q.jump | (e_q.branch & br_taken(e_q.br_type, zero_e, lt_e, ltu_e)));

  assign reg_write_m  = m_q.reg_write;
  assign result_src_m = m_q.result_src;
  assign mem_write_m  = m_q.mem_write;
  assign valid_m      = m_q.valid;

  assign reg_write_w  = w_q.reg_write;
  assign result_src_w = w_q.result_src;
  assign valid_w      = w_q.valid;
  assign illegal_w    = w_q.illegal;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: a full-ISA instance (index 0) and a reduced instance (index 1)
// share stimulus and are compared against a mnemonic-level reference model.
module tb_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_d;
  logic        valid_d, flush_e, zero_e, lt_e, ltu_e;

  logic [2:0] imm_src_d    [2];
  logic       illegal_d    [2];
  logic       reg_write_e  [2], reg_write_m [2], reg_write_w [2];
  logic [1:0] result_src_e [2], result_src_m [2], result_src_w [2];
  logic       mem_write_e  [2], mem_write_m [2];
  logic [3:0] alu_ctrl_e   [2];
  logic [1:0] alu_src_a_e  [2];
  logic       alu_src_b_e  [2], jump_e [2], jalr_e [2], branch_e [2], pc_src_e [2];
  logic       valid_e [2], valid_m [2], valid_w [2], illegal_w [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ctrl_pipe #(.FULL_ALU(g == 0 ? 1 : 0), .FULL_BR(g == 0 ? 1 : 0)) u_dut (
      .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .valid_d(valid_d), .flush_e(flush_e),
      .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
      .imm_src_d(imm_src_d[g]), .illegal_d(illegal_d[g]),
      .reg_write_e(reg_write_e[g]), .reg_write_m(reg_write_m[g]), .reg_write_w(reg_write_w[g]),
      .result_src_e(result_src_e[g]), .result_src_m(result_src_m[g]), .result_src_w(result_src_w[g]),
      .mem_write_e(mem_write_e[g]), .mem_write_m(mem_write_m[g]), .alu_ctrl_e(alu_ctrl_e[g]),
      .alu_src_a_e(alu_src_a_e[g]), .alu_src_b_e(alu_src_b_e[g]), .jump_e(jump_e[g]),
      .jalr_e(jalr_e[g]), .branch_e(branch_e[g]), .pc_src_e(pc_src_e[g]),
      .valid_e(valid_e[g]), .valid_m(valid_m[g]), .valid_w(valid_w[g]), .illegal_w(illegal_w[g])
    );
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0] imm; logic ill; logic rw; logic [1:0] rs; logic mw; logic [3:0] alu;
    logic [1:0] sa; logic sb; logic j; logic jr; logic br; logic [2:0] bt;
  } dec_t;
  typedef struct packed { logic v; dec_t c; } stg_t;

  stg_t s_e [2], s_m [2], s_w [2];

  string r_names [8]   = '{"add", "sll", "slt", "sltu", "xor", "srl", "or", "and"};
  string i_names [8]   = '{"addi", "slli", "slti", "sltiu", "xori", "srli", "ori", "andi"};
  string b_names [8]   = '{"beq", "bne", "bad", "bad", "blt", "bge", "bltu", "bgeu"};
  string alu_tab [10]  = '{"add", "sub", "and", "or", "sll", "srl", "xor", "slt", "sltu", "sra"};

  function automatic string mnem(input logic [31:0] i);
    logic [6:0] op, f7; logic [2:0] f3; string m;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25]; m = "bad";
    if (op == 7'h33) begin
      if (f7 == 7'h00) m = r_names[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) m = "sub";
      else if (f7 == 7'h20 && f3 == 3'd5) m = "sra";
    end else if (op == 7'h13) begin
      m = i_names[f3];
      if (f3 == 3'd1 && f7 != 7'h00) m = "bad";
      if (f3 == 3'd5) m = (f7 == 7'h00) ? "srli" : (f7 == 7'h20) ? "srai" : "bad";
    end
    else if (op == 7'h03 && f3 == 3'd2) m = "lw";
    else if (op == 7'h23 && f3 == 3'd2) m = "sw";
    else if (op == 7'h37) m = "lui";
    else if (op == 7'h17) m = "auipc";
    else if (op == 7'h6F) m = "jal";
    else if (op == 7'h67 && f3 == 3'd0) m = "jalr";
    else if (op == 7'h63) m = b_names[f3];
    return m;
  endfunction

  function automatic dec_t model_dec(input logic [31:0] i, input bit full);
    string m, base; dec_t d; bit is_br, is_r, is_i;
    m = mnem(i); d = '0;
    is_r  = (i[6:0] == 7'h33); is_i = (i[6:0] == 7'h13);
    is_br = (i[6:0] == 7'h63) && (m != "bad");
    base  = is_i ? ((m == "srai") ? "sra" : r_names[i[14:12]]) : m;
    if (!full && (is_r || is_i) && (base == "xor" || base == "slt" || base == "sltu" || base == "sra")) m = "bad";
    if (!full && (m == "blt" || m == "bge" || m == "bltu" || m == "bgeu")) m = "bad";
    if (m == "bad") begin d.ill = 1'b1; return d; end
    d.imm = (m == "sw") ? 3'b001 : is_br ? 3'b010 : (m == "lui" || m == "auipc") ? 3'b011 :
            (m == "jal") ? 3'b100 : 3'b000;
    d.alu = 4'd0;
    for (int k = 0; k < 10; k++) if ((is_r || is_i) && alu_tab[k] == base) d.alu = 4'(k);
    if (is_br) d.alu = 4'd1;
    d.rw = (m != "sw") && !is_br && (i[11:7] != 5'd0);
    d.rs = (m == "lw") ? 2'b01 : (m == "jal" || m == "jalr") ? 2'b10 : 2'b00;
    d.mw = (m == "sw");
    d.sa = (m == "lui") ? 2'b10 : (m == "auipc" || m == "jal") ? 2'b01 : 2'b00;
    d.sb = !is_r && !is_br;
    d.j  = (m == "jal" || m == "jalr");
    d.jr = (m == "jalr");
    d.br = is_br;
    d.bt = is_br ? i[14:12] : 3'b000;
    return d;
  endfunction

  function automatic logic exp_pc(input stg_t s, input logic z, input logic l, input logic lu);
    logic t;
    case (s.c.bt)
      3'd0: t = z;  3'd1: t = !z;  3'd4: t = l;  3'd5: t = !l;  3'd6: t = lu;  3'd7: t = !lu;
      default: t = 1'b0;
    endcase
    return s.v && (s.c.j || (s.c.br && t));
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_stages(input int k);
    chk($sformatf("d%0d.valid_e", k), 32'(valid_e[k]), 32'(s_e[k].v));
    chk($sformatf("d%0d.reg_write_e", k), 32'(reg_write_e[k]), 32'(s_e[k].c.rw));
    chk($sformatf("d%0d.result_src_e", k), 32'(result_src_e[k]), 32'(s_e[k].c.rs));
    chk($sformatf("d%0d.mem_write_e", k), 32'(mem_write_e[k]), 32'(s_e[k].c.mw));
    chk($sformatf("d%0d.alu_ctrl_e", k), 32'(alu_ctrl_e[k]), 32'(s_e[k].c.alu));
    chk($sformatf("d%0d.alu_src_a_e", k), 32'(alu_src_a_e[k]), 32'(s_e[k].c.sa));
    chk($sformatf("d%0d.alu_src_b_e", k), 32'(alu_src_b_e[k]), 32'(s_e[k].c.sb));
    chk($sformatf("d%0d.jump_jalr_branch_e", k), {29'd0, jump_e[k], jalr_e[k], branch_e[k]},
        {29'd0, s_e[k].c.j, s_e[k].c.jr, s_e[k].c.br});
    chk($sformatf("d%0d.m_stage", k), {27'd0, valid_m[k], reg_write_m[k], result_src_m[k], mem_write_m[k]},
        {27'd0, s_m[k].v, s_m[k].c.rw, s_m[k].c.rs, s_m[k].c.mw});
    chk($sformatf("d%0d.w_stage", k), {27'd0, valid_w[k], reg_write_w[k], result_src_w[k], illegal_w[k]},
        {27'd0, s_w[k].v, s_w[k].c.rw, s_w[k].c.rs, s_w[k].c.ill});
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin s_e[k] = '0; s_m[k] = '0; s_w[k] = '0; end
  endtask

  // One pipeline cycle: decode check, clock edge, stage check, then branch resolution.
  task automatic cycle(input logic [31:0] ins, input logic v, input logic fl,
                       input logic z, input logic l, input logic lu);
    dec_t d;
    instr_d = ins; valid_d = v; flush_e = fl;
    #1;
    for (int k = 0; k < 2; k++) begin
      d = model_dec(ins, k == 0);
      chk($sformatf("d%0d.imm_src_d %08h", k, ins), 32'(imm_src_d[k]), 32'(d.imm));
      chk($sformatf("d%0d.illegal_d %08h", k, ins), 32'(illegal_d[k]), 32'(d.ill));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      s_w[k] = s_m[k]; s_m[k] = s_e[k];
      if (fl || !v) s_e[k] = '0;
      else begin s_e[k].v = 1'b1; s_e[k].c = model_dec(ins, k == 0); end
    end
    #1;
    for (int k = 0; k < 2; k++) check_stages(k);
    zero_e = z; lt_e = l; ltu_e = lu;
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("d%0d.pc_src_e", k), 32'(pc_src_e[k]), 32'(exp_pc(s_e[k], z, l, lu)));
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 2; k++)
      chk($sformatf("%s d%0d all outputs", tag, k),
          {16'd0, reg_write_e[k], reg_write_m[k], reg_write_w[k], mem_write_e[k], mem_write_m[k],
           alu_src_b_e[k], jump_e[k], jalr_e[k], branch_e[k], pc_src_e[k], valid_e[k], valid_m[k],
           valid_w[k], illegal_w[k], 2'b00},
          32'(result_src_e[k]) | 32'(result_src_m[k]) | 32'(result_src_w[k]) |
          32'(alu_ctrl_e[k]) | 32'(alu_src_a_e[k]));
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    string nm; logic [31:0] ins; logic v, fl, z, l, lu;
    logic rw_e; logic [3:0] alu_e; logic v_e; logic pc; logic ill_red;
  } vec_t;

  logic [31:0] templ [27] = '{
    32'h00000033, 32'h40000033, 32'h00001033, 32'h00002033, 32'h00003033, 32'h00004033,
    32'h00005033, 32'h40005033, 32'h00006033, 32'h00007033, 32'h00000013, 32'h00001013,
    32'h00005013, 32'h40005013, 32'h00004013, 32'h00002003, 32'h00002023, 32'h00000037,
    32'h00000017, 32'h0000006F, 32'h00000067, 32'h00000063, 32'h00001063, 32'h00004063,
    32'h00005063, 32'h00006063, 32'h00007063};

  initial begin
    vec_t vecs [11];
    logic [31:0] ins, sel;
    vecs[0]  = '{"add_x0",   32'h00208033, 1, 0, 0, 0, 0, 0, 4'd0, 1, 0, 0};
    vecs[1]  = '{"sra",      32'h4020D1B3, 1, 0, 0, 0, 0, 1, 4'd9, 1, 0, 1};
    vecs[2]  = '{"beq_z1",   32'h00208463, 1, 0, 1, 0, 0, 0, 4'd1, 1, 1, 0};
    vecs[3]  = '{"beq_z0",   32'h00208463, 1, 0, 0, 1, 1, 0, 4'd1, 1, 0, 0};
    vecs[4]  = '{"blt_lt1",  32'h0020C463, 1, 0, 0, 1, 0, 0, 4'd1, 1, 1, 1};
    vecs[5]  = '{"lw_flush", 32'h0000A183, 1, 1, 0, 0, 0, 0, 4'd0, 0, 0, 0};
    vecs[6]  = '{"lw_inval", 32'h0000A183, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0};
    vecs[7]  = '{"jal",      32'h008000EF, 1, 0, 0, 0, 0, 1, 4'd0, 1, 1, 0};
    vecs[8]  = '{"xor",      32'h0020C1B3, 1, 0, 0, 0, 0, 1, 4'd6, 1, 0, 1};
    vecs[9]  = '{"addi",     32'h00500093, 1, 0, 0, 0, 0, 1, 4'd0, 1, 0, 0};
    vecs[10] = '{"bne_z1",   32'h00209463, 1, 0, 1, 0, 0, 0, 4'd1, 1, 0, 0};

    rst_n = 1'b0; instr_d = 32'd0; valid_d = 1'b0; flush_e = 1'b0;
    zero_e = 1'b1; lt_e = 1'b1; ltu_e = 1'b1;
    model_reset();
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    foreach (vecs[n]) begin
      cycle(vecs[n].ins, vecs[n].v, vecs[n].fl, vecs[n].z, vecs[n].l, vecs[n].lu);
      chk({vecs[n].nm, ".reg_write_e"}, 32'(reg_write_e[0]), 32'(vecs[n].rw_e));
      chk({vecs[n].nm, ".alu_ctrl_e"}, 32'(alu_ctrl_e[0]), 32'(vecs[n].alu_e));
      chk({vecs[n].nm, ".valid_e"}, 32'(valid_e[0]), 32'(vecs[n].v_e));
      chk({vecs[n].nm, ".pc_src_e"}, 32'(pc_src_e[0]), 32'(vecs[n].pc));
      chk({vecs[n].nm, ".illegal_d reduced"}, 32'(illegal_d[1]), 32'(vecs[n].ill_red));
    end

    // Illegal SRA in the reduced instance retires as illegal three edges after issue.
    cycle(32'h4020D1B3, 1, 0, 0, 0, 0);
    cycle(32'h00000000, 0, 0, 0, 0, 0);
    cycle(32'h00000000, 0, 0, 0, 0, 0);
    chk("sra_reduced.illegal_w", 32'(illegal_w[1]), 32'd1);
    chk("sra_reduced.reg_write_w", 32'(reg_write_w[1]), 32'd0);
    chk("sra_full.illegal_w", 32'(illegal_w[0]), 32'd0);
    chk("sra_full.reg_write_w", 32'(reg_write_w[0]), 32'd1);

    // Flushed lw is dropped; the following valid lw reaches M as a load.
    cycle(32'h0000A183, 1, 1, 0, 0, 0);
    chk("lw_flush.valid_e", 32'(valid_e[0]), 32'd0);
    cycle(32'h0000A183, 1, 0, 0, 0, 0);
    cycle(32'h00000013, 0, 0, 0, 0, 0);
    chk("lw.result_src_m", 32'(result_src_m[0]), 32'd1);
    chk("lw.valid_m", 32'(valid_m[0]), 32'd1);

    // Illegal instruction flushed in D never reaches W.
    cycle(32'hFFFFFFFF, 1, 1, 0, 0, 0);
    cycle(32'h00000000, 0, 0, 0, 0, 0);
    cycle(32'h00000000, 0, 0, 0, 0, 0);
    chk("flushed_illegal.illegal_w", 32'(illegal_w[0]), 32'd0);

    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 7);
      if (sel == 0) ins = $urandom;
      else if (sel == 1) ins = {$urandom_range(0, 127) == 0 ? 7'h20 : 7'($urandom), 10'($urandom),
                               3'($urandom), 5'($urandom), 7'h33};
      else ins = templ[$urandom_range(0, 26)] | ($urandom & 32'h01FF8F80);
      cycle(ins, ($urandom_range(0, 5) != 0), ($urandom_range(0, 7) == 0),
            1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Asynchronous reset mid-pipe clears everything without a clock edge.
    cycle(32'h008000EF, 1, 0, 1, 1, 1);
    cycle(32'h002081B3, 1, 0, 1, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cycle(32'h008000EF, 1, 0, 0, 0, 0);
    chk("post_reset.jal.pc_src_e", 32'(pc_src_e[0]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
